// File: rtl/pipelined_adder_pkg.sv
// Shared types and elaboration helpers for the carry-pipelined adder.
package pipelined_adder_pkg;

    // Per-stage control record that travels down the carry pipeline.
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

    function automatic bit cfg_ok(input int width, input int stages);
        return (width >= 1) && (stages >= 1) && ((width % stages) == 0);
    endfunction

    function automatic int slice_w(input int width, input int stages);
        return (stages >= 1) ? (width / stages) : 1;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Purely combinational SW-bit add with carry in and carry out.
module adder_slice #(
    parameter int SW = 8
) (
    input  logic [SW-1:0] a_i,
    input  logic [SW-1:0] b_i,
    input  logic          ci_i,
    output logic [SW-1:0] s_o,
    output logic          co_o
);

    logic [SW:0] sum;

    assign sum  = {1'b0, a_i} + {1'b0, b_i} + {{SW{1'b0}}, ci_i};
    assign s_o  = sum[SW-1:0];
    assign co_o = sum[SW];

endmodule

// File: rtl/pipelined_adder.sv
// Carry-pipelined WIDTH-bit adder with valid/ready handshake on both sides.
// Define PIPELINED_ADDER_SUB_EN to add the SUB_i port (A - B when SUB_i = 1).
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic             CI_i,
`ifdef PIPELINED_ADDER_SUB_EN
    input  logic             SUB_i,
`endif
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] S_o,
    output logic             CO_o
);

    localparam int SW = slice_w(WIDTH, STAGES);

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
        $error("pipelined_adder: STAGES must be >= 1 and divide WIDTH");
    end

    logic       en;
    stage_ctl_t ctl_q [STAGES];
`ifdef PIPELINED_ADDER_SUB_EN
    logic       sub_q [STAGES];
`endif

    // Global stall: everything advances unless a valid result is being held.
    assign en      = ready_i | ~valid_o;
    assign ready_o = en;
    assign valid_o = ctl_q[STAGES-1].valid;
    assign CO_o    = ctl_q[STAGES-1].carry;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SW-1:0] a_s, b_s, b_x, s_c, sum_r;
        logic          c_s, c_c, sub_s, vld_s;
        stage_ctl_t    ctl_r;

        if (k == 0) begin : g_head
            assign a_s   = A_i[SW-1:0];
            assign b_s   = B_i[SW-1:0];
            assign vld_s = valid_i;
`ifdef PIPELINED_ADDER_SUB_EN
            assign sub_s = SUB_i;
`else
            assign sub_s = 1'b0;
`endif
            assign c_s   = CI_i ^ sub_s;
        end else begin : g_skew
            // Operand slice k waits k cycles so it meets the carry from below.
            logic [SW-1:0] a_skw [k];
            logic [SW-1:0] b_skw [k];

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int j = 0; j < k; j++) begin
                        a_skw[j] <= '0;
                        b_skw[j] <= '0;
                    end
                end else if (en) begin
                    a_skw[0] <= A_i[k*SW +: SW];
                    b_skw[0] <= B_i[k*SW +: SW];
                    for (int j = 1; j < k; j++) begin
                        a_skw[j] <= a_skw[j-1];
                        b_skw[j] <= b_skw[j-1];
                    end
                end
            end

            assign a_s   = a_skw[k-1];
            assign b_s   = b_skw[k-1];
            assign vld_s = ctl_q[k-1].valid;
            assign c_s   = ctl_q[k-1].carry;
`ifdef PIPELINED_ADDER_SUB_EN
            assign sub_s = sub_q[k-1];
`else
            assign sub_s = 1'b0;
`endif
        end

        assign b_x = b_s ^ {SW{sub_s}};

        adder_slice #(.SW(SW)) u_slice (
            .a_i  (a_s),
            .b_i  (b_x),
            .ci_i (c_s),
            .s_o  (s_c),
            .co_o (c_c)
        );

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                ctl_r <= '0;
                sum_r <= '0;
            end else if (en) begin
                ctl_r.valid <= vld_s;
                ctl_r.carry <= c_c;
                sum_r       <= s_c;
            end
        end

        assign ctl_q[k] = ctl_r;

`ifdef PIPELINED_ADDER_SUB_EN
        if (k < STAGES-1) begin : g_sub
            logic sub_r;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    sub_r <= 1'b0;
                end else if (en) begin
                    sub_r <= sub_s;
                end
            end

            assign sub_q[k] = sub_r;
        end else begin : g_sub_last
            assign sub_q[k] = 1'b0;
        end
`endif

        if (k < STAGES-1) begin : g_dsk
            // Result slice k waits for the upper slices before leaving together.
            localparam int D = STAGES-1-k;
            logic [SW-1:0] dsk [D];

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int j = 0; j < D; j++) dsk[j] <= '0;
                end else if (en) begin
                    dsk[0] <= sum_r;
                    for (int j = 1; j < D; j++) dsk[j] <= dsk[j-1];
                end
            end

            assign S_o[k*SW +: SW] = dsk[D-1];
        end else begin : g_last
            assign S_o[k*SW +: SW] = sum_r;
        end
    end

endmodule
